// File: rtl/clk_rst_seq.sv
// Reset sequencer and clock-enable controller: waits for lock, stabilises, releases domain resets in order.
// Optional macro CLK_RST_SEQ_SYNC_EN adds 2-flop synchronizers on locked_i and clk_en_i.
module clk_rst_seq #(
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  input  logic [NUM_DOMAINS-1:0] clk_en_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_i,
  output logic [NUM_DOMAINS-1:0] rstn_o,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic                   ready_o
);

  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CW = (LW > GW) ? LW : GW;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABILIZE = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic                   w_lock;
  logic [NUM_DOMAINS-1:0] w_en;

`ifdef CLK_RST_SEQ_SYNC_EN
  logic [1:0]             r_lock_sync;
  logic [NUM_DOMAINS-1:0] r_en_s1;
  logic [NUM_DOMAINS-1:0] r_en_s2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock_sync <= '0;
      r_en_s1     <= '0;
      r_en_s2     <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], locked_i};
      r_en_s1     <= clk_en_i;
      r_en_s2     <= r_en_s1;
    end
  end

  assign w_lock = r_lock_sync[1];
  assign w_en   = r_en_s2;
`else
  assign w_lock = locked_i;
  assign w_en   = clk_en_i;
`endif

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [IW-1:0]          r_idx, w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_rstn, w_rstn_nxt;
  logic [NUM_DOMAINS-1:0] r_clk_en, w_clk_en_nxt;
  logic                   r_ready, w_ready_nxt;
  logic [HW-1:0]          r_hold [NUM_DOMAINS];
  logic [HW-1:0]          w_hold_nxt [NUM_DOMAINS];
  logic                   w_act;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_WAIT_LOCK;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rstn   <= '0;
      r_clk_en <= '0;
      r_ready  <= 1'b0;
      for (int unsigned k = 0; k < NUM_DOMAINS; k++) r_hold[k] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_rstn   <= w_rstn_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_ready  <= w_ready_nxt;
      for (int unsigned k = 0; k < NUM_DOMAINS; k++) r_hold[k] <= w_hold_nxt[k];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rstn_nxt  = r_rstn;
    w_ready_nxt = r_ready;
    for (int unsigned k = 0; k < NUM_DOMAINS; k++) w_hold_nxt[k] = r_hold[k];
    w_act        = (r_state == S_RELEASE) || (r_state == S_RUN);
    // Domains still in reset stay clocked so their synchronous reset logic can settle.
    w_clk_en_nxt = w_act ? (w_en | ~r_rstn) : '0;

    if ((r_state != S_WAIT_LOCK) && !w_lock) begin
      w_state_nxt  = S_WAIT_LOCK;
      w_cnt_nxt    = '0;
      w_idx_nxt    = '0;
      w_rstn_nxt   = '0;
      w_clk_en_nxt = '0;
      w_ready_nxt  = 1'b0;
      for (int unsigned k = 0; k < NUM_DOMAINS; k++) w_hold_nxt[k] = '0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (w_lock) begin
            w_state_nxt = S_STABILIZE;
            w_cnt_nxt   = '0;
          end
        end
        S_STABILIZE: begin
          if (r_cnt == CW'(LOCK_CYCLES - 1)) begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (r_cnt == '0) w_rstn_nxt[r_idx] = 1'b1;
          if (r_cnt == CW'(GAP_CYCLES - 1)) begin
            w_cnt_nxt = '0;
            if (r_idx == IW'(NUM_DOMAINS - 1)) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_RUN: begin
          for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            if (sw_rst_i[k]) begin
              w_rstn_nxt[k] = 1'b0;
              w_hold_nxt[k] = HW'(HOLD_CYCLES);
            end else if (r_hold[k] != '0) begin
              w_hold_nxt[k] = r_hold[k] - HW'(1);
              if (r_hold[k] == HW'(1)) w_rstn_nxt[k] = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_WAIT_LOCK;
      endcase
    end
  end

  assign rstn_o   = r_rstn;
  assign clk_en_o = r_clk_en;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: timing-rule reference model, scripted scenarios, then random stimulus.
// Honours CLK_RST_SEQ_SYNC_EN by shifting expectations by the synchronizer depth.
module tb_clk_rst_seq;

  localparam int N    = 3;
  localparam int LOCK = 16;
  localparam int GAP  = 4;
  localparam int HOLD = 8;
`ifdef CLK_RST_SEQ_SYNC_EN
  localparam int OFS = 2;
`else
  localparam int OFS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         locked = 1'b0;
  logic [N-1:0] en_i = '0;
  logic [N-1:0] sw_i = '0;
  logic [N-1:0] rstn_o;
  logic [N-1:0] clk_en_o;
  logic         ready_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  clk_rst_seq #(
    .NUM_DOMAINS(N),
    .LOCK_CYCLES(LOCK),
    .GAP_CYCLES (GAP),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .locked_i(locked),
    .clk_en_i(en_i),
    .sw_rst_i(sw_i),
    .rstn_o  (rstn_o),
    .clk_en_o(clk_en_o),
    .ready_o (ready_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: outputs derived from edge distance to the first lock edge and hold deadlines.
  int           m_edge = 0;
  bit           m_have_e0 = 0;
  int           m_e0 = 0;
  int           m_hold_until [N];
  logic [N-1:0] m_rstn = '0;
  logic [N-1:0] m_en = '0;
  logic         m_rdy = 1'b0;
  logic         m_lk1 = 1'b0, m_lk2 = 1'b0;
  logic [N-1:0] m_en1 = '0, m_en2 = '0;

  always @(posedge clk or posedge rst) begin
    logic         lk;
    logic [N-1:0] en, prev_rstn;
    bit           run;
    int           t;
    if (rst) begin
      m_have_e0 = 0;
      m_rstn = '0; m_en = '0; m_rdy = 1'b0;
      m_lk1 = 1'b0; m_lk2 = 1'b0; m_en1 = '0; m_en2 = '0;
      for (int k = 0; k < N; k++) m_hold_until[k] = 0;
    end else begin
      m_edge++;
`ifdef CLK_RST_SEQ_SYNC_EN
      lk = m_lk2; en = m_en2;
      m_lk2 = m_lk1; m_lk1 = locked;
      m_en2 = m_en1; m_en1 = en_i;
`else
      lk = locked; en = en_i;
`endif
      if (!m_have_e0) begin
        if (lk) begin m_have_e0 = 1; m_e0 = m_edge; end
      end else if (!lk) begin
        m_have_e0 = 0;
        m_rstn = '0; m_en = '0; m_rdy = 1'b0;
        for (int k = 0; k < N; k++) m_hold_until[k] = 0;
      end else begin
        t = m_edge - m_e0;
        prev_rstn = m_rstn;
        run = m_rdy;
        for (int k = 0; k < N; k++) begin
          if (run && sw_i[k]) m_hold_until[k] = m_edge + HOLD;
          m_rstn[k] = (t >= LOCK + 1 + k * GAP) && (m_edge >= m_hold_until[k]);
          m_en[k]   = (t >= LOCK + 1) && (en[k] || !prev_rstn[k]);
        end
        m_rdy = (t >= LOCK + N * GAP);
      end
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if ({rstn_o, clk_en_o, ready_o} !== {m_rstn, m_en, m_rdy}) begin
      n_fail++;
      $display("FAIL model_cmp cyc=%0d rstn=%b/%b clk_en=%b/%b ready=%b/%b (actual/required)",
               cyc, rstn_o, m_rstn, clk_en_o, m_en, ready_o, m_rdy);
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_rstn", rstn_o, '0);
    chk("reset_clk_en", clk_en_o, '0);
    chk("reset_ready", {2'b00, ready_o}, '0);
    #1 rst = 1'b0;

    // Power-up sequence: lock first sampled at edge 10.
    wait_edge(9);  locked = 1'b1;
    wait_edge(26 + OFS); chk("rel_none", rstn_o, 3'b000); chk("en_pre", clk_en_o, 3'b000);
    wait_edge(27 + OFS); chk("rel_d0", rstn_o, 3'b001); chk("en_rel0", clk_en_o, 3'b111);
    wait_edge(28 + OFS); chk("en_follow", clk_en_o, 3'b110);
    wait_edge(30 + OFS); chk("rel_d0_hold", rstn_o, 3'b001);
    wait_edge(31 + OFS); chk("rel_d1", rstn_o, 3'b011);
    wait_edge(35 + OFS); chk("rel_d2", rstn_o, 3'b111);
    wait_edge(37 + OFS); chk("ready_pre", {2'b00, ready_o}, 3'b000);
    wait_edge(38 + OFS); chk("ready_up", {2'b00, ready_o}, 3'b001);

    // Software reset on domain 1, re-requested mid-hold.
    wait_edge(50);  en_i = 3'b111;
    wait_edge(99);  sw_i = 3'b010;
    wait_edge(100); sw_i = 3'b000; chk("sw_drop", rstn_o, 3'b101);
    wait_edge(103); sw_i = 3'b010;
    wait_edge(104); sw_i = 3'b000; chk("sw_reload", rstn_o, 3'b101);
    wait_edge(108); chk("sw_en", clk_en_o, 3'b111); chk("sw_ready", {2'b00, ready_o}, 3'b001);
    wait_edge(111); chk("sw_held", rstn_o, 3'b101);
    wait_edge(112); chk("sw_rise", rstn_o, 3'b111);

    // Enable follow, then lock loss colliding with a software reset.
    wait_edge(119); en_i = 3'b010;
    wait_edge(119 + OFS); chk("en_old", clk_en_o, 3'b111);
    wait_edge(120 + OFS); chk("en_new", clk_en_o, 3'b010);
    wait_edge(129 - OFS); locked = 1'b0;
    wait_edge(129); sw_i = 3'b001;
    wait_edge(130); sw_i = 3'b000;
    chk("loss_rstn", rstn_o, '0); chk("loss_en", clk_en_o, '0); chk("loss_ready", {2'b00, ready_o}, '0);

    // Relock, then a one-cycle dropout at stabilisation count 9.
    wait_edge(134); locked = 1'b1;
    wait_edge(144); locked = 1'b0;
    wait_edge(145); locked = 1'b1;
    wait_edge(145 + OFS); chk("stab_drop", rstn_o, '0);
    wait_edge(162 + OFS); chk("restab_pre", rstn_o, 3'b000);
    wait_edge(163 + OFS); chk("restab_d0", rstn_o, 3'b001);

    // Async reset mid-release.
    wait_edge(165 + OFS); chk("mid_rel", rstn_o, 3'b001);
    #2 rst = 1'b1;
    #1;
    chk("arst_rstn", rstn_o, '0); chk("arst_en", clk_en_o, '0); chk("arst_ready", {2'b00, ready_o}, '0);
    wait_edge(167 + OFS); #2 rst = 1'b0;
    wait_edge(184 + 2 * OFS); chk("replay_pre", rstn_o, 3'b000);
    wait_edge(185 + 2 * OFS); chk("replay_d0", rstn_o, 3'b001);
    wait_edge(195 + 2 * OFS); chk("replay_rdy_pre", {2'b00, ready_o}, 3'b000);
    wait_edge(196 + 2 * OFS); chk("replay_rdy", {2'b00, ready_o}, 3'b001);

    // Randomized traffic checked cycle by cycle against the model.
    repeat (3000) begin
      @(negedge clk);
      if (locked) begin
        if ($urandom_range(0, 149) == 0) locked = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        locked = 1'b1;
      end
      for (int k = 0; k < N; k++) sw_i[k] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) en_i = N'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
